// File: rtl/prog_mem_ldr_pkg.sv
// Shared definitions for the program-memory loader.
//   DefDataSize / DefAddrSize : default instruction width and address width
//   state_e                   : loader FSM state encoding
package prog_mem_ldr_pkg;

  localparam int unsigned DefDataSize = 6;
  localparam int unsigned DefAddrSize = 5;

  typedef enum logic [1:0] {
    StClear,
    StRun,
    StLoad
  } state_e;

endpackage

// File: rtl/prog_mem_ldr_if.sv
// Loader and fetch bus for prog_mem_ldr.
//   ld_start/ld_valid/ld_data/ld_last/ld_ready : program load handshake
//   fetch_en/fetch_addr                        : fetch request
//   fetch_data/fetch_valid/fetch_oob           : registered fetch result
//   prog_len/busy                              : status
// Modport master drives requests; modport slave is the loader block.
interface prog_mem_ldr_if
  import prog_mem_ldr_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DefDataSize,
  parameter int unsigned ADDR_SIZE = DefAddrSize
);

  logic                 ld_start;
  logic                 ld_valid;
  logic [DATA_SIZE-1:0] ld_data;
  logic                 ld_last;
  logic                 ld_ready;
  logic                 fetch_en;
  logic [ADDR_SIZE-1:0] fetch_addr;
  logic [DATA_SIZE-1:0] fetch_data;
  logic                 fetch_valid;
  logic                 fetch_oob;
  logic [ADDR_SIZE:0]   prog_len;
  logic                 busy;

  modport master (
    output ld_start, ld_valid, ld_data, ld_last, fetch_en, fetch_addr,
    input  ld_ready, fetch_data, fetch_valid, fetch_oob, prog_len, busy
  );

  modport slave (
    input  ld_start, ld_valid, ld_data, ld_last, fetch_en, fetch_addr,
    output ld_ready, fetch_data, fetch_valid, fetch_oob, prog_len, busy
  );

endinterface

// File: rtl/prog_mem_ram.sv
// Program memory: one write port, one registered read port.
//   clk, rstn          : clock, async active-low reset (read register only)
//   we, waddr, wdata   : write port
//   re, raddr, rdata   : read port, rdata updates the cycle after re, else holds
// The array itself has no reset; it is zeroed by the loader's clear sweep.
module prog_mem_ram
  import prog_mem_ldr_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DefDataSize,
  parameter int unsigned ADDR_SIZE = DefAddrSize
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] waddr,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic                 re,
  input  logic [ADDR_SIZE-1:0] raddr,
  output logic [DATA_SIZE-1:0] rdata
);

  logic [DATA_SIZE-1:0] mem [2**ADDR_SIZE];
  logic [DATA_SIZE-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/prog_mem_ldr.sv
// Program-memory loader: clears memory after reset, accepts program loads over a
// valid/ready stream and serves 1-cycle-latency fetches while idle.
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : prog_mem_ldr_if.slave (load handshake, fetch port, prog_len, busy)
module prog_mem_ldr
  import prog_mem_ldr_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DefDataSize,
  parameter int unsigned ADDR_SIZE = DefAddrSize
) (
  input  logic           clk,
  input  logic           rstn,
  prog_mem_ldr_if.slave  bus
);

  localparam int unsigned DEPTH = 2**ADDR_SIZE;
  localparam logic [ADDR_SIZE-1:0] LastAddr = ADDR_SIZE'(DEPTH - 1);

  state_e               state_q;
  logic [ADDR_SIZE-1:0] clr_ptr_q;
  logic [ADDR_SIZE-1:0] wr_ptr_q;
  logic [ADDR_SIZE:0]   prog_len_q;
  logic                 fetch_valid_q;
  logic                 fetch_oob_q;

  logic                 xfer;
  logic                 ld_end;
  logic                 fetch_go;
  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_waddr;
  logic [DATA_SIZE-1:0] mem_wdata;

  assign xfer     = (state_q == StLoad) && bus.ld_valid;
  // A full memory ends the load even without ld_last.
  assign ld_end   = xfer && (bus.ld_last || (wr_ptr_q == LastAddr));
  assign fetch_go = (state_q == StRun) && bus.fetch_en;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= StClear;
      clr_ptr_q     <= '0;
      wr_ptr_q      <= '0;
      prog_len_q    <= '0;
      fetch_valid_q <= 1'b0;
      fetch_oob_q   <= 1'b0;
    end else begin
      fetch_valid_q <= fetch_go;
      if (fetch_go) begin
        fetch_oob_q <= ({1'b0, bus.fetch_addr} >= prog_len_q);
      end
      unique case (state_q)
        StClear: begin
          clr_ptr_q <= clr_ptr_q + 1'b1;
          if (clr_ptr_q == LastAddr) begin
            state_q <= StRun;
          end
        end
        StRun: begin
          // A same-cycle fetch is still served above from pre-load contents.
          if (bus.ld_start) begin
            state_q  <= StLoad;
            wr_ptr_q <= '0;
          end
        end
        StLoad: begin
          if (xfer) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            if (ld_end) begin
              prog_len_q <= {1'b0, wr_ptr_q} + 1'b1;
              state_q    <= StRun;
            end
          end
        end
        default: state_q <= StClear;
      endcase
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_ptr_q;
    mem_wdata = bus.ld_data;
    if (state_q == StClear) begin
      mem_we    = 1'b1;
      mem_waddr = clr_ptr_q;
      mem_wdata = '0;
    end else if (xfer) begin
      mem_we = 1'b1;
    end
  end

  prog_mem_ram #(
    .DATA_SIZE(DATA_SIZE),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_ram (
    .clk  (clk),
    .rstn (rstn),
    .we   (mem_we),
    .waddr(mem_waddr),
    .wdata(mem_wdata),
    .re   (fetch_go),
    .raddr(bus.fetch_addr),
    .rdata(bus.fetch_data)
  );

  assign bus.ld_ready    = (state_q == StLoad);
  assign bus.busy        = (state_q != StRun);
  assign bus.prog_len    = prog_len_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fetch_oob   = fetch_oob_q;

endmodule

// File: tb/tb_prog_mem_ldr.sv
// Self-checking bench for prog_mem_ldr: directed scenarios plus random traffic,
// checked every cycle against a behavioural model of memory contents and mode.
module tb_prog_mem_ldr;

  localparam int DW = 6;
  localparam int AW = 5;
  localparam int DEPTH = 32;

  logic clk;
  logic rstn;

  prog_mem_ldr_if #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) bus ();

  prog_mem_ldr #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp;
  int n_fail;

  // Behavioural model
  logic [DW-1:0] m_mem [DEPTH];
  int            m_clr_left;
  bit            m_loading;
  int            m_wp;
  int            m_len;
  logic [DW-1:0] m_fd;
  bit            m_fv;
  bit            m_foob;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic compare_outputs();
    check("busy", 32'(bus.busy), 32'(m_clr_left > 0 || m_loading));
    check("ld_ready", 32'(bus.ld_ready), 32'(m_loading));
    check("prog_len", 32'(bus.prog_len), 32'(m_len));
    check("fetch_valid", 32'(bus.fetch_valid), 32'(m_fv));
    check("fetch_data", 32'(bus.fetch_data), 32'(m_fd));
    if (m_fv) check("fetch_oob", 32'(bus.fetch_oob), 32'(m_foob));
  endtask

  // One clock: capture inputs, advance model at the edge, compare 1 ns later.
  task automatic tick();
    logic s, v, l, fe;
    logic [DW-1:0] d;
    logic [AW-1:0] fa;
    s = bus.ld_start; v = bus.ld_valid; l = bus.ld_last; d = bus.ld_data;
    fe = bus.fetch_en; fa = bus.fetch_addr;
    @(posedge clk);
    m_fv = 1'b0;
    if (m_clr_left > 0) begin
      m_mem[DEPTH - m_clr_left] = '0;
      m_clr_left--;
    end else if (m_loading) begin
      if (v) begin
        m_mem[m_wp] = d;
        if (l || m_wp == DEPTH - 1) begin
          m_len = m_wp + 1;
          m_loading = 1'b0;
        end
        m_wp++;
      end
    end else begin
      if (fe) begin
        m_fv = 1'b1;
        m_fd = m_mem[fa];
        m_foob = (int'(fa) >= m_len);
      end
      if (s) begin
        m_loading = 1'b1;
        m_wp = 0;
      end
    end
    #1;
    compare_outputs();
  endtask

  task automatic drive(input logic s, input logic v, input logic [DW-1:0] d, input logic l,
                       input logic fe, input logic [AW-1:0] fa);
    bus.ld_start = s; bus.ld_valid = v; bus.ld_data = d; bus.ld_last = l;
    bus.fetch_en = fe; bus.fetch_addr = fa;
    tick();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic fetch(input logic [AW-1:0] a);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1, a);
  endtask

  // Asynchronous reset asserted mid-cycle, released on a falling edge.
  task automatic do_reset();
    rstn = 1'b0;
    #2;
    m_clr_left = DEPTH; m_loading = 1'b0; m_wp = 0; m_len = 0;
    m_fd = '0; m_fv = 1'b0; m_foob = 1'b0;
    compare_outputs();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy && n < 100) begin
      idle();
      n++;
    end
  endtask

  initial begin
    int n;
    logic [DW-1:0] w4 [4];
    n_cmp = 0;
    n_fail = 0;
    w4[0] = 6'h01; w4[1] = 6'h02; w4[2] = 6'h03; w4[3] = 6'h3F;
    bus.ld_start = 0; bus.ld_valid = 0; bus.ld_data = '0; bus.ld_last = 0;
    bus.fetch_en = 0; bus.fetch_addr = '0;

    // Reset, clear sweep length, cleared contents
    do_reset();
    check("rst_busy", 32'(bus.busy), 32'd1);
    check("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
    wait_idle(n);
    check("clear_cycles", 32'(n), 32'd32);
    for (int a = 0; a < DEPTH; a++) begin
      fetch(AW'(a));
      check("clr_data", 32'(bus.fetch_data), 32'd0);
      check("clr_oob", 32'(bus.fetch_oob), 32'd1);
    end

    // Four-word load ending on ld_last
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    check("load_ready", 32'(bus.ld_ready), 32'd1);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, w4[i], i == 3, 1'b0, '0);
    check("len4", 32'(bus.prog_len), 32'd4);
    fetch(5'd3);
    check("fetch3_data", 32'(bus.fetch_data), 32'h3F);
    check("fetch3_oob", 32'(bus.fetch_oob), 32'd0);
    fetch(5'd4);
    check("fetch4_oob", 32'(bus.fetch_oob), 32'd1);

    // Full-depth load without ld_last auto-terminates
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b1, DW'($urandom), 1'b0, 1'b0, '0);
    check("len32", 32'(bus.prog_len), 32'd32);
    check("auto_end_busy", 32'(bus.busy), 32'd0);
    drive(1'b0, 1'b1, 6'h2A, 1'b0, 1'b0, '0);  // must be ignored in RUN

    // Gapped handshake: only valid cycles write
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, 6'h11, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 6'h3E, 1'b1, 1'b0, '0);
    drive(1'b0, 1'b1, 6'h22, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 6'h3D, 1'b1, 1'b0, '0);
    drive(1'b0, 1'b1, 6'h33, 1'b1, 1'b0, '0);
    check("len3", 32'(bus.prog_len), 32'd3);
    fetch(5'd0); check("gap0", 32'(bus.fetch_data), 32'h11);
    fetch(5'd1); check("gap1", 32'(bus.fetch_data), 32'h22);
    fetch(5'd2); check("gap2", 32'(bus.fetch_data), 32'h33);
    fetch(5'd3); check("gap3_oob", 32'(bus.fetch_oob), 32'd1);

    // Fetch and ld_start together: old data, then LOAD
    drive(1'b1, 1'b0, '0, 1'b0, 1'b1, 5'd0);
    check("same_fv", 32'(bus.fetch_valid), 32'd1);
    check("same_fd", 32'(bus.fetch_data), 32'h11);
    check("same_ready", 32'(bus.ld_ready), 32'd1);

    // Reset after two of five words aborts the load
    drive(1'b0, 1'b1, 6'h05, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, 6'h06, 1'b0, 1'b0, '0);
    do_reset();
    check("abort_busy", 32'(bus.busy), 32'd1);
    wait_idle(n);
    check("abort_clear_cycles", 32'(n), 32'd32);
    check("abort_len", 32'(bus.prog_len), 32'd0);
    for (int a = 0; a < DEPTH; a++) begin
      fetch(AW'(a));
      check("abort_zero", 32'(bus.fetch_data), 32'd0);
    end

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      drive($urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0, DW'($urandom),
            $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, AW'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
